spi: RTL and testbench

SPI -- requirements
Module: spi

---
 rtl/spi_if.sv | 30 +++
 rtl/spi.sv | 119 +++++++++++
 tb/tb_spi.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_if.sv
// SPI master bus bundle: transfer request/word in, serial pins and completion pulse out.
// The master modport is the controller side; the slave modport is whoever drives requests.
interface spi_if #(
   parameter int DATA_WIDTH = 12
);
   logic                  start;
   logic [DATA_WIDTH-1:0] din;
   logic                  cs;
   logic                  mosi;
   logic                  sclk;
   logic                  done;

   modport master (
      input  start,
      input  din,
      output cs,
      output mosi,
      output sclk,
      output done
   );

   modport slave (
      output start,
      output din,
      input  cs,
      input  mosi,
      input  sclk,
      input  done
   );
endinterface

// File: rtl/spi.sv
// SPI mode-0 master: sends one DATA_WIDTH word MSB first per request.
// All pins are registered; sclk is derived from a SCLK_HALF-cycle divider.
module spi #(
   parameter int DATA_WIDTH = 12,
   parameter int SCLK_HALF  = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   spi_if.master bus
);
   localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [1:0]            state_r, state_s;
   logic [DATA_WIDTH-1:0] shreg_r, shreg_s;
   logic [CNT_W-1:0]      cnt_r,   cnt_s;
   logic [DIV_W-1:0]      div_r,   div_s;
   logic                  cs_r,    cs_s;
   logic                  mosi_r,  mosi_s;
   logic                  sclk_r,  sclk_s;
   logic                  done_r,  done_s;

   // Next-state and next-output computation for the transfer sequencer.
   always_comb begin
      state_s = state_r;
      shreg_s = shreg_r;
      cnt_s   = cnt_r;
      div_s   = div_r;
      cs_s    = cs_r;
      mosi_s  = mosi_r;
      sclk_s  = sclk_r;
      done_s  = 1'b0;
      case (state_r)
         // The DONE exit edge is also the first IDLE decision point, so a held
         // start restarts with only the single DONE cycle of cs high in between.
         IDLE, DONE: begin
            sclk_s = 1'b0;
            div_s  = '0;
            cnt_s  = '0;
            if (bus.start) begin
               state_s = SHIFT;
               shreg_s = bus.din;
               cs_s    = 1'b0;
               mosi_s  = bus.din[DATA_WIDTH-1];
            end else begin
               state_s = IDLE;
               cs_s    = 1'b1;
               mosi_s  = 1'b0;
            end
         end
         SHIFT: begin
            if (div_r == DIV_MAX) begin
               div_s = '0;
               if (sclk_r == 1'b0) begin
                  sclk_s = 1'b1;
               end else begin
                  sclk_s = 1'b0;
                  cnt_s  = cnt_r + CNT_W'(1);
                  if (cnt_r == CNT_LAST) begin
                     state_s = DONE;
                     done_s  = 1'b1;
                     cs_s    = 1'b1;
                     mosi_s  = 1'b0;
                  end else begin
                     shreg_s = {shreg_r[DATA_WIDTH-2:0], 1'b0};
                     mosi_s  = shreg_r[DATA_WIDTH-2];
                  end
               end
            end else begin
               div_s = div_r + DIV_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
            shreg_s = '0;
            cnt_s   = '0;
            div_s   = '0;
            cs_s    = 1'b1;
            mosi_s  = 1'b0;
            sclk_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         shreg_r <= '0;
         cnt_r   <= '0;
         div_r   <= '0;
         cs_r    <= 1'b1;
         mosi_r  <= 1'b0;
         sclk_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         shreg_r <= shreg_s;
         cnt_r   <= cnt_s;
         div_r   <= div_s;
         cs_r    <= cs_s;
         mosi_r  <= mosi_s;
         sclk_r  <= sclk_s;
         done_r  <= done_s;
      end
   end

   assign bus.cs   = cs_r;
   assign bus.mosi = mosi_r;
   assign bus.sclk = sclk_r;
   assign bus.done = done_r;
endmodule

// File: tb/tb_spi.sv
// Directed bench for spi: table of words plus abort, back-to-back and SCLK_HALF=1 sequences.
module tb_spi;
   logic clk;
   logic rst_n;

   spi_if #(.DATA_WIDTH(12)) if0 ();
   spi_if #(.DATA_WIDTH(12)) if1 ();

   spi #(.DATA_WIDTH(12), .SCLK_HALF(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
   spi #(.DATA_WIDTH(12), .SCLK_HALF(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] din;
      logic        poke;
      logic [11:0] exp_bits;
   } vec_t;

   vec_t vt[4];
   int   n_cmp;
   int   n_bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   // One transfer on u0: start held 2 cycles, optional busy poke, 20-cycle tail after done.
   task automatic run_xfer(input logic [11:0] d, input logic poke,
                           output logic [11:0] bits, output int rises, output int cs_low,
                           output int cs_falls, output int dones, output int done_cyc,
                           output int mosi_bad, output int finished);
      int   cyc;
      int   tail;
      logic prev_sclk;
      logic prev_cs;
      logic prev_mosi;
      logic prev_done;
      bits = '0; rises = 0; cs_low = 0; cs_falls = 0; dones = 0; done_cyc = 0;
      mosi_bad = 0; finished = 0;
      cyc = 0; tail = 0;
      prev_sclk = if0.sclk; prev_cs = if0.cs; prev_mosi = if0.mosi; prev_done = if0.done;
      if0.din   = d;
      if0.start = 1'b1;
      while (tail < 20 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2)                  if0.start = 1'b0;
         if (poke && cyc == 40) begin   if0.start = 1'b1; if0.din = 12'h555; end
         if (poke && cyc == 41)         if0.start = 1'b0;
         if (if0.cs == 1'b0) cs_low++;
         if (prev_cs == 1'b1 && if0.cs == 1'b0) cs_falls++;
         if (prev_sclk == 1'b0 && if0.sclk == 1'b1) begin
            rises++;
            bits = {bits[10:0], if0.mosi};
         end
         if (prev_cs == 1'b0 && if0.cs == 1'b0 && if0.mosi != prev_mosi &&
             !(prev_sclk == 1'b1 && if0.sclk == 1'b0)) mosi_bad++;
         if (if0.done) done_cyc++;
         if (prev_done == 1'b0 && if0.done == 1'b1) dones++;
         if (dones > 0) tail++;
         prev_sclk = if0.sclk; prev_cs = if0.cs; prev_mosi = if0.mosi; prev_done = if0.done;
      end
      finished = (tail >= 20) ? 1 : 0;
   endtask

   initial begin
      logic [11:0] bits;
      int          rises, cs_low, cs_falls, dones, done_cyc, mosi_bad, finished;
      int          cyc, ndone, gap, nd;
      logic        prev_sclk, prev_done;
      logic [11:0] bits2;
      int          rises2, sclk_bad;
      logic        prev_cs1;

      vt[0] = '{din: 12'hAAA, poke: 1'b0, exp_bits: 12'b1010_1010_1010};
      vt[1] = '{din: 12'h001, poke: 1'b0, exp_bits: 12'b0000_0000_0001};
      vt[2] = '{din: 12'hFFF, poke: 1'b0, exp_bits: 12'b1111_1111_1111};
      vt[3] = '{din: 12'hAAA, poke: 1'b1, exp_bits: 12'b1010_1010_1010};

      n_cmp = 0; n_bad = 0;
      if0.start = 1'b0; if0.din = '0;
      if1.start = 1'b0; if1.din = '0;
      rst_n = 1'b0;
      #12;
      chk("reset_pins", {28'd0, if0.cs, if0.sclk, if0.mosi, if0.done}, 32'b1000);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_pins", {28'd0, if0.cs, if0.sclk, if0.mosi, if0.done}, 32'b1000);

      for (int i = 0; i < 4; i++) begin
         run_xfer(vt[i].din, vt[i].poke, bits, rises, cs_low, cs_falls, dones, done_cyc,
                  mosi_bad, finished);
         chk($sformatf("v%0d_finished", i), finished, 1);
         chk($sformatf("v%0d_bits", i), {20'd0, bits}, {20'd0, vt[i].exp_bits});
         chk($sformatf("v%0d_rises", i), rises, 12);
         chk($sformatf("v%0d_cs_low", i), cs_low, 96);
         chk($sformatf("v%0d_cs_falls", i), cs_falls, 1);
         chk($sformatf("v%0d_dones", i), dones, 1);
         chk($sformatf("v%0d_done_width", i), done_cyc, 1);
         chk($sformatf("v%0d_mosi_stable", i), mosi_bad, 0);
      end

      // Reset abort after 5 sclk rising edges.
      if0.din = 12'hAAA; if0.start = 1'b1;
      cyc = 0; rises = 0; prev_sclk = if0.sclk;
      while (rises < 5 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) if0.start = 1'b0;
         if (prev_sclk == 1'b0 && if0.sclk == 1'b1) rises++;
         prev_sclk = if0.sclk;
      end
      chk("abort_reached_5_edges", rises, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_pins", {28'd0, if0.cs, if0.sclk, if0.mosi, if0.done}, 32'b1000);
      @(negedge clk); rst_n = 1'b1;
      nd = 0;
      repeat (120) begin
         @(posedge clk); #1;
         if (if0.done || !if0.cs) nd++;
      end
      chk("abort_no_done_stay_idle", nd, 0);
      run_xfer(12'hF0F, 1'b0, bits, rises, cs_low, cs_falls, dones, done_cyc, mosi_bad, finished);
      chk("post_abort_bits", {20'd0, bits}, {20'd0, 12'b1111_0000_1111});
      chk("post_abort_rises", rises, 12);
      chk("post_abort_dones", dones, 1);

      // Back-to-back with start held; din changes mid-transfer feed only the second word.
      if0.din = 12'hAAA; if0.start = 1'b1;
      cyc = 0; ndone = 0; gap = 0; bits2 = '0; rises2 = 0;
      prev_sclk = if0.sclk; prev_done = if0.done;
      while (ndone < 2 && cyc < 600) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 20) if0.din = 12'h3C5;
         if (prev_done == 1'b0 && if0.done == 1'b1) ndone++;
         if (ndone == 1 && if0.cs == 1'b1) gap++;
         if (ndone == 1 && if0.cs == 1'b0) if0.start = 1'b0;
         if (ndone == 1 && prev_sclk == 1'b0 && if0.sclk == 1'b1) begin
            rises2++;
            bits2 = {bits2[10:0], if0.mosi};
         end
         prev_sclk = if0.sclk; prev_done = if0.done;
      end
      if0.start = 1'b0;
      chk("b2b_two_dones", ndone, 2);
      chk("b2b_cs_gap", gap, 1);
      chk("b2b_second_bits", {20'd0, bits2}, {20'd0, 12'b0011_1100_0101});
      chk("b2b_second_rises", rises2, 12);
      repeat (5) @(posedge clk);
      #1;
      chk("b2b_back_idle", {28'd0, if0.cs, if0.sclk, if0.mosi, if0.done}, 32'b1000);

      // SCLK_HALF=1 instance: sclk = clk/2, 24-cycle transfer.
      if1.din = 12'hC3A; if1.start = 1'b1;
      cyc = 0; nd = 0; cs_low = 0; bits = '0; rises = 0; sclk_bad = 0;
      prev_sclk = if1.sclk; prev_cs1 = if1.cs;
      while (nd == 0 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) if1.start = 1'b0;
         if (if1.cs == 1'b0) cs_low++;
         if (prev_cs1 == 1'b0 && if1.cs == 1'b0 && if1.sclk == prev_sclk) sclk_bad++;
         if (prev_sclk == 1'b0 && if1.sclk == 1'b1) begin
            rises++;
            bits = {bits[10:0], if1.mosi};
         end
         if (if1.done) nd++;
         prev_sclk = if1.sclk; prev_cs1 = if1.cs;
      end
      chk("h1_done", nd, 1);
      chk("h1_cs_low", cs_low, 24);
      chk("h1_bits", {20'd0, bits}, {20'd0, 12'b1100_0011_1010});
      chk("h1_rises", rises, 12);
      chk("h1_sclk_every_clk", sclk_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
